// File: rtl/fft_pkg.sv
// Shared FFT definitions: sizing helpers, complex-sample slice bounds,
// the bit-reversal function and the loader state encoding.
package fft_pkg;

    localparam int unsigned DEF_SAMPLES  = 8;
    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned LOG2_SAMPLES = $clog2(DEF_SAMPLES);
    localparam int unsigned PAIR_IDX_W   = (LOG2_SAMPLES > 1) ? LOG2_SAMPLES - 1 : 1;

    // Packed complex layout: imag in the upper half, real in the lower half.
    localparam int unsigned RE_LSB = 0;
    localparam int unsigned RE_MSB = DEF_WIDTH / 2 - 1;
    localparam int unsigned IM_LSB = DEF_WIDTH / 2;
    localparam int unsigned IM_MSB = DEF_WIDTH - 1;

    typedef enum logic {FILL, DRAIN} loader_state_t;

    // Reverses the low nbits of value; bits above nbits come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                                input int unsigned nbits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[5'(i)] = value[5'(nbits - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Sample buffer: one synchronous write port, two combinational read ports.
// Contents are never reset.
module fft_sample_ram #(
    parameter int unsigned  DEPTH = 8,
    parameter int unsigned  WIDTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/fft_bitrev_loader.sv
// FFT input stage: writes a frame at bit-reversed addresses, then drains
// adjacent slot pairs to the first butterfly stage.
module fft_bitrev_loader
    import fft_pkg::*;
#(
    parameter int unsigned  SAMPLES = DEF_SAMPLES,
    parameter int unsigned  WIDTH   = DEF_WIDTH,
    localparam int unsigned AW      = $clog2(SAMPLES),
    localparam int unsigned PIW     = (SAMPLES > 2) ? $clog2(SAMPLES / 2) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             pair_valid,
    input  logic             pair_ready,
    output logic [WIDTH-1:0] pair_a,
    output logic [WIDTH-1:0] pair_b,
    output logic [PIW-1:0]   pair_index,
    output logic             frame_done,
    output logic             frame_error
);

    localparam logic [AW-1:0]  WR_LAST = AW'(SAMPLES - 1);
    localparam logic [PIW-1:0] RD_LAST = PIW'(SAMPLES / 2 - 1);

    loader_state_t    r_state, w_state_d;
    logic [AW-1:0]    r_wr_cnt, w_wr_cnt_d;
    logic [PIW-1:0]   r_rd_cnt, w_rd_cnt_d;
    logic             r_frame_done, w_frame_done_d;
    logic             r_frame_error, w_frame_error_d;
    logic             w_accept, w_pair_fire, w_we;
    logic [AW-1:0]    w_waddr, w_raddr_a, w_raddr_b;
    logic [WIDTH-1:0] w_rdata_a, w_rdata_b;

    assign in_ready    = (r_state == FILL);
    assign pair_valid  = (r_state == DRAIN);
    assign w_accept    = in_valid & in_ready;
    assign w_pair_fire = pair_valid & pair_ready;
    // Reset wins over a same-cycle handshake, so the buffer is not touched.
    assign w_we        = w_accept & ~reset;

    assign w_waddr   = AW'(bit_reverse(32'(r_wr_cnt), AW));
    assign w_raddr_a = AW'({r_rd_cnt, 1'b0});
    assign w_raddr_b = AW'({r_rd_cnt, 1'b1});

    fft_sample_ram #(
        .DEPTH (SAMPLES),
        .WIDTH (WIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (in_data),
        .i_raddr_a (w_raddr_a),
        .i_raddr_b (w_raddr_b),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    always_comb begin
        w_state_d       = r_state;
        w_wr_cnt_d      = r_wr_cnt;
        w_rd_cnt_d      = r_rd_cnt;
        w_frame_done_d  = 1'b0;
        w_frame_error_d = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (r_wr_cnt == WR_LAST) begin
                        w_wr_cnt_d      = '0;
                        w_state_d       = DRAIN;
                        w_frame_error_d = ~in_last;
                    end else if (in_last) begin
                        // Truncated frame: flag it and restart the fill.
                        w_wr_cnt_d      = '0;
                        w_frame_error_d = 1'b1;
                    end else begin
                        w_wr_cnt_d = r_wr_cnt + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (w_pair_fire) begin
                    if (r_rd_cnt == RD_LAST) begin
                        w_rd_cnt_d     = '0;
                        w_state_d      = FILL;
                        w_frame_done_d = 1'b1;
                    end else begin
                        w_rd_cnt_d = r_rd_cnt + PIW'(1);
                    end
                end
            end
            default: w_state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FILL;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_wr_cnt      <= w_wr_cnt_d;
            r_rd_cnt      <= w_rd_cnt_d;
            r_frame_done  <= w_frame_done_d;
            r_frame_error <= w_frame_error_d;
        end
    end

    assign pair_a      = pair_valid ? w_rdata_a : '0;
    assign pair_b      = pair_valid ? w_rdata_b : '0;
    assign pair_index  = pair_valid ? r_rd_cnt : '0;
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Scoreboard bench for fft_bitrev_loader (SAMPLES=8, WIDTH=16): the driver
// queues expected pairs, a negedge monitor pops and compares on each handshake.
module tb_fft_bitrev_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        pair_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_ready, pair_valid, frame_done, frame_error;
    logic [15:0] pair_a, pair_b;
    logic [1:0]  pair_index;

    fft_bitrev_loader #(
        .SAMPLES (8),
        .WIDTH   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .pair_valid  (pair_valid),
        .pair_ready  (pair_ready),
        .pair_a      (pair_a),
        .pair_b      (pair_b),
        .pair_index  (pair_index),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  idx;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_pops = 0;
    int    n_done = 0;
    int    n_err_pulses = 0;
    int    rdy_mode = 0;
    // Slot p of a frame holds sample br[p] (3-bit bit reversal, worked by hand).
    int    br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [15:0] base);
        pair_t p;
        for (int k = 0; k < 4; k++) begin
            p.a   = base + 16'(br[2 * k]);
            p.b   = base + 16'(br[2 * k + 1]);
            p.idx = 2'(k);
            exp_q.push_back(p);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] base, input int nsamp, input int last_pos,
                        input bit hold, input bit chk_done_start);
        int wait_cyc;
        for (int j = 0; j < nsamp; j++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(j);
            in_last  = (j == last_pos);
            wait_cyc = 0;
            while (!in_ready && wait_cyc < 100) begin
                cyc();
                wait_cyc++;
            end
            if (!in_ready) begin
                n_checks++;
                n_errors++;
                $display("FAIL in_ready_timeout: actual=0 required=1");
            end
            if (j == 0 && chk_done_start) check("start_on_done", 32'(frame_done), 1);
            cyc();
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            cyc();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain_timeout: actual=%0d pending required=0", name, exp_q.size());
        end
        repeat (3) cyc();
    endtask

    // pair_ready: held high, or toggled every cycle when rdy_mode=1
    initial begin
        forever begin
            cyc();
            pair_ready = (rdy_mode == 0) ? 1'b1 : ~pair_ready;
        end
    end

    // Monitor: samples at negedge, pops and compares on each accepted pair.
    logic        held_v = 1'b0;
    logic [15:0] held_a, held_b;
    logic [1:0]  held_i;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                held_v = 1'b0;
            end else begin
                if (frame_done) begin
                    n_done++;
                    check("done_in_ready", 32'(in_ready), 1);
                    check("done_no_pair", 32'(pair_valid), 0);
                end
                if (frame_error) n_err_pulses++;
                if (pair_valid && held_v) begin
                    check("stall_hold_a", 32'(pair_a), 32'(held_a));
                    check("stall_hold_b", 32'(pair_b), 32'(held_b));
                    check("stall_hold_idx", 32'(pair_index), 32'(held_i));
                end
                if (pair_valid && pair_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_pair: actual a=%h b=%h idx=%0d required none",
                                 pair_a, pair_b, pair_index);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("pair_a", 32'(pair_a), 32'(mon_e.a));
                        check("pair_b", 32'(pair_b), 32'(mon_e.b));
                        check("pair_index", 32'(pair_index), 32'(mon_e.idx));
                        n_pops++;
                    end
                end else if (pair_valid) begin
                    held_v = 1'b1;
                    held_a = pair_a;
                    held_b = pair_b;
                    held_i = pair_index;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int d0, e0, p0, c;

        // Reset state
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_pair_valid", 32'(pair_valid), 0);
        check("rst_pair_a", 32'(pair_a), 0);
        check("rst_pair_b", 32'(pair_b), 0);
        check("rst_pair_index", 32'(pair_index), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        cyc();

        // T1: ramp 0..7, no stalls; done 4 cycles after the last accept
        d0 = n_done;
        e0 = n_err_pulses;
        push_frame(16'h0000);
        send(16'h0000, 8, 7, 1'b0, 1'b0);
        check("t1_first_pair_valid", 32'(pair_valid), 1);
        c = 0;
        while (!frame_done && c < 50) begin
            cyc();
            c++;
        end
        check("t1_latency", 32'(c), 4);
        wait_drain("t1");
        check("t1_done_cnt", 32'(n_done - d0), 1);
        check("t1_err_cnt", 32'(n_err_pulses - e0), 0);

        // T2: same frame with pair_ready toggling
        d0 = n_done;
        rdy_mode = 1;
        push_frame(16'h0000);
        send(16'h0000, 8, 7, 1'b0, 1'b0);
        wait_drain("t2");
        rdy_mode = 0;
        cyc();
        check("t2_done_cnt", 32'(n_done - d0), 1);

        // T3: early in_last on n=4, then a full frame 0x0100..
        d0 = n_done;
        e0 = n_err_pulses;
        send(16'h0000, 5, 4, 1'b0, 1'b0);
        check("t3_err_pulse", 32'(frame_error), 1);
        repeat (3) begin
            cyc();
            check("t3_no_pair", 32'(pair_valid), 0);
        end
        push_frame(16'h0100);
        send(16'h0100, 8, 7, 1'b0, 1'b0);
        wait_drain("t3");
        check("t3_err_cnt", 32'(n_err_pulses - e0), 1);
        check("t3_done_cnt", 32'(n_done - d0), 1);

        // T4: in_last never asserted, frame still drains
        d0 = n_done;
        e0 = n_err_pulses;
        push_frame(16'h2A50);
        send(16'h2A50, 8, -1, 1'b0, 1'b0);
        check("t4_err_pulse", 32'(frame_error), 1);
        check("t4_drain_entered", 32'(pair_valid), 1);
        wait_drain("t4");
        check("t4_err_cnt", 32'(n_err_pulses - e0), 1);
        check("t4_done_cnt", 32'(n_done - d0), 1);

        // T5: reset after the second pair of a drain
        d0 = n_done;
        p0 = n_pops;
        push_frame(16'h8000);
        send(16'h8000, 8, 7, 1'b0, 1'b0);
        c = 0;
        while (n_pops < p0 + 2 && c < 50) begin
            cyc();
            c++;
        end
        check("t5_two_pairs", 32'(n_pops - p0), 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_pair_valid", 32'(pair_valid), 0);
        check("t5_pair_a", 32'(pair_a), 0);
        check("t5_pair_b", 32'(pair_b), 0);
        check("t5_pair_index", 32'(pair_index), 0);
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_frame_done", 32'(frame_done), 0);
        repeat (3) cyc();
        check("t5_no_done", 32'(n_done - d0), 0);
        d0 = n_done;
        push_frame(16'h7F81);
        send(16'h7F81, 8, 7, 1'b0, 1'b0);
        wait_drain("t5");
        check("t5_done_cnt", 32'(n_done - d0), 1);

        // T6: back-to-back frames with in_valid held high throughout
        d0 = n_done;
        e0 = n_err_pulses;
        push_frame(16'h0C00);
        push_frame(16'h0D00);
        send(16'h0C00, 8, 7, 1'b1, 1'b0);
        send(16'h0D00, 8, 7, 1'b0, 1'b1);
        wait_drain("t6");
        check("t6_done_cnt", 32'(n_done - d0), 2);
        check("t6_err_cnt", 32'(n_err_pulses - e0), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
- Input stage of the radix-2 DIT FFT, directly upstream of the butterfly unit.
- Accepts a serial stream of SAMPLES packed complex samples over a valid/ready handshake and stores each at its bit-reversed address.
- Once the frame is full, presents the first-stage butterfly operand pairs (adjacent bit-reversed slots) one per handshake, with the pair index used for twiddle lookup.
- Single buffer: fill and drain alternate and do not overlap.

Parameters:
- SAMPLES, 8, samples per frame; power of two, >= 2.
- WIDTH, 16, packed complex width; imag in [WIDTH-1:WIDTH/2], real in [WIDTH/2-1:0], each half two's complement; even.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  packed complex sample.
- in_last  input  1  marks the final sample of a frame.
- pair_valid  output  1  pair_a, pair_b and pair_index are valid.
- pair_ready  input  1  butterfly consumes the pair.
- pair_a  output  WIDTH  butterfly input1 = buffer slot 2k.
- pair_b  output  WIDTH  butterfly input2 = buffer slot 2k+1.
- pair_index  output  max(1,$clog2(SAMPLES/2))  k, the pair number.
- frame_done  output  1  one-cycle pulse after the last pair is accepted.
- frame_error  output  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Reset (sync, active-high):
  - state=FILL, wr_cnt=0, rd_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - pair_valid=0, pair_a=0, pair_b=0, pair_index=0, frame_done=0, frame_error=0.
  - Buffer contents are not cleared.
  - Reset overrides any handshake in the same cycle.
  - Reset mid-FILL or mid-DRAIN discards the partial frame. No frame_done is produced.
- State FILL:
  - in_ready=1, pair_valid=0.
  - Accept = in_valid & in_ready.
  - On accept: mem[bitrev(wr_cnt)] <= in_data; wr_cnt++.
- FILL -> DRAIN: on accept with wr_cnt==SAMPLES-1. wr_cnt <= 0.
  - If in_last=0 on that sample: pulse frame_error; the frame is still drained.
- Early in_last (accept with in_last=1 and wr_cnt<SAMPLES-1):
  - pulse frame_error, wr_cnt <= 0, stay in FILL (truncated frame dropped).
- State DRAIN:
  - in_ready=0, pair_valid=1.
  - pair_a=mem[2*rd_cnt], pair_b=mem[2*rd_cnt+1], pair_index=rd_cnt.
  - Outputs are read combinationally from registered state and held stable while pair_ready=0.
  - On pair_valid & pair_ready: rd_cnt++.
- DRAIN -> FILL: when the accepted pair has rd_cnt==SAMPLES/2-1. rd_cnt <= 0.
  - frame_done=1 and in_ready=1 in the next cycle.
- Latency:
  - First pair_valid arrives the cycle after the SAMPLES-th sample is accepted.
  - Minimum frame period = SAMPLES + SAMPLES/2 cycles with no stalls.
- When pair_valid=0: pair_a, pair_b and pair_index are forced to 0.
- Data is stored bit-exact; no arithmetic or saturation in this block.
- SAMPLES==2: bitrev is the identity and pair_index is 1 bit, constant 0.
- in_valid while in_ready=0 is ignored, and no data is captured.
- in_last is ignored outside an accept.

Decomposition:
- Shared package fft_pkg:
  - function bit_reverse(value, nbits);
  - localparam helpers LOG2_SAMPLES and PAIR_IDX_W;
  - complex half-width split constants (re/im slice bounds);
  - typedef enum logic {FILL, DRAIN} loader_state_t.
- One sub-module: fft_sample_ram, SAMPLES x WIDTH, one synchronous write port and two combinational read ports. Reusable by later FFT stages.

Test Plan (SAMPLES=8, WIDTH=16):
- Reset, then stream samples real=n, imag=0 (in_data=n, n=0..7) with in_last on n=7 and pair_ready=1 -> pairs (0,4),(2,6),(1,5),(3,7) with pair_index 0..3 on consecutive cycles. frame_done pulses once. in_ready=1 on that same cycle.
- Same frame with pair_ready toggling 1/0 every cycle -> each pair is held stable across stall cycles. Order and values are unchanged. No pair is duplicated or skipped.
- in_last asserted on the 5th sample (n=4) -> frame_error pulse, no pair_valid. A following full 8-sample frame 0x0100..0x0107 drains as (0x0100,0x0104),(0x0102,0x0106),(0x0101,0x0105),(0x0103,0x0107).
- 8 samples with in_last never asserted -> frame_error pulses on the 8th accept, and the frame still drains normally.
- reset asserted for one cycle after the second pair of a DRAIN -> next cycle pair_valid=0, pair outputs=0, in_ready=1, no frame_done. A new full frame drains correctly.
- Two back-to-back frames with in_valid held high continuously -> no sample is accepted during DRAIN. The second frame starts on the cycle frame_done pulses, and both frames drain correctly.
